fft_r2_merge: RTL and testbench
===============================

FFT_R2_MERGE -- requirements
Module: fft_r2_merge

Interface
REQ-001 Parameter DW, 18, width of input data samples (signed).
REQ-002 Parameter LOG2N, 4, log2 of transform size N; HALF = N/2; LOG2N range is 2..10.
REQ-003 Parameter SCALE, 0, 0 = outputs grow one bit with saturation, 1 = outputs are halved with rounding.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  when high in IDLE, begins one merge pass.
REQ-007 in_we  input  1  input buffer write strobe.
REQ-008 in_sel  input  1  input bank select: 0 = even half-spectrum E, 1 = odd half-spectrum O.
REQ-009 in_addr  input  LOG2N-1  input bin index k.
REQ-010 in_r, in_i  input  DW each  signed input sample.
REQ-011 out_addr  input  LOG2N  output bin index.
REQ-012 out_r, out_i  output  DW+1 each  signed registered result read data.
REQ-013 busy  output  1  high from the cycle after start is accepted until done.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 ovf  output  1  sticky saturation flag for the current or last pass.

Function
REQ-016 Each pass computes X[k] = E[k] + W^k*O[k] and X[k+HALF] = E[k] - W^k*O[k] for k = 0..HALF-1, with W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N).
REQ-017 Twiddles are 18-bit signed, 1.0 = 2^14, rounded to nearest, and W^0 = (16384, 0).
REQ-018 The complex product is full precision; each component is computed as (sum + 2^13) >>> 14 (arithmetic shift).
REQ-019 With SCALE=0, each sum or difference saturates to the DW+1 signed range; any saturation sets ovf.
REQ-020 With SCALE=1, each output is (E ± P + 1) >>> 1, saturated to DW+1.
REQ-021 The FSM has states IDLE, RUN, DRAIN, DONE.
 - IDLE -> RUN when start=1 (cycle 0); this transition clears ovf and raises busy.
 - RUN issues k = 0..HALF-1 on cycles 1..HALF, then goes to DRAIN.
 - DRAIN waits for the 3-stage pipeline (read, multiply, round/add/write) to empty; the last write occurs on cycle HALF+3.
 - DONE: done=1 and busy=0 on cycle HALF+4, then return to IDLE.
REQ-022 One butterfly is issued per cycle; the multiplier is a single instance, pipelined.
REQ-023 start while not in IDLE is ignored, with no restart and no extra done pulse.
REQ-024 in_we is honoured only in IDLE or DONE; writes while busy are dropped and do not alter the buffers.
REQ-025 start and in_we in the same IDLE cycle: the write lands first and the pass uses the new value.
REQ-026 out_r/out_i show result[out_addr] one cycle after out_addr is applied; reads are legal in any state.
REQ-027 While busy, a read returns the previous pass's value for bins not yet rewritten.
REQ-028 The output buffer retains results until the next pass overwrites them; back-to-back passes need no reload of unchanged bins.

Reset
REQ-029 On rst: state = IDLE, busy = 0, done = 0, ovf = 0, out_r = 0, out_i = 0, and pipeline valids are cleared.
REQ-030 rst during RUN or DRAIN aborts the pass on the next edge with no done pulse; results written so far remain, and the rest are stale.
REQ-031 Buffer RAM contents are not cleared by rst.

Structure
REQ-032 Shared package fft_pkg holds TW_W = 18, TW_FRAC = 14, the rounding constant, and the state enumeration.
REQ-033 Sub-module fft_twiddle_rom(LOG2N) supplies a registered twiddle for address k with 1-cycle latency, aligned to the buffer read stage.
REQ-034 Input buffers are two HALF-deep dual-port RAMs, and the output buffer is one N-deep RAM; all map to block/distributed RAM.

Verification
REQ-035 DW=18, LOG2N=4, SCALE=0; E[k] = (1000, 0), O = 0; start -> done on cycle 12; all 16 outputs = (1000, 0); ovf = 0.
REQ-036 E = 0, O[4] = (1000, 0), other O = 0 -> X[4] = (0, -1000), X[12] = (0, 1000), all others 0.
REQ-037 E[2] = (131071, 0), O[2] = (131071, 131071) -> X[2].r = 262143 (saturated), ovf = 1; the next start clears ovf.
REQ-038 Same stimulus as REQ-035 with SCALE=1 -> all outputs = (500, 0).
REQ-039 start re-pulsed on cycles 3 and 7 plus in_we on cycle 5 -> exactly one done, on cycle 12, and the input buffers are unchanged.
REQ-040 rst on cycle 6 of a pass -> busy = 0 next cycle, no done; a fresh start then yields the REQ-035 results.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and twiddle generator for the radix-2 merge stage.
// Twiddles are Q3.14 in an 18-bit signed word; W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N).
package fft_pkg;

    localparam int  TW_W      = 18;
    localparam int  TW_FRAC   = 14;
    localparam int  RND_CONST = 1 << (TW_FRAC - 1);
    localparam real PI        = 3.14159265358979323846;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Elaboration-time only: real component of W^k (im=0) or imaginary component (im=1),
    // scaled by 2^TW_FRAC and rounded to nearest.
    function automatic int tw_value(input int k, input int log2n, input bit im);
        real a;
        real x;
        a = 2.0 * PI * real'(k) / real'(1 << log2n);
        x = im ? -$sin(a) : $cos(a);
        x = x * real'(1 << TW_FRAC);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Twiddle ROM for k = 0..N/2-1 with one registered read cycle, so the twiddle lines up
// with the input-buffer read stage of the butterfly pipeline.
module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int LOG2N = 4
) (
    input  logic                    i_clk,
    input  logic [LOG2N-2:0]        i_addr,
    output logic signed [TW_W-1:0]  o_tw_r,
    output logic signed [TW_W-1:0]  o_tw_i
);

    localparam int HALF = 1 << (LOG2N - 1);

    logic signed [TW_W-1:0] w_cos [HALF];
    logic signed [TW_W-1:0] w_sin [HALF];

    for (genvar g = 0; g < HALF; g++) begin : g_tab
        localparam int TW_RE = tw_value(g, LOG2N, 1'b0);
        localparam int TW_IM = tw_value(g, LOG2N, 1'b1);
        assign w_cos[g] = TW_W'(TW_RE);
        assign w_sin[g] = TW_W'(TW_IM);
    end

    always_ff @(posedge i_clk) begin
        o_tw_r <= w_cos[i_addr];
        o_tw_i <= w_sin[i_addr];
    end

endmodule

// File: rtl/fft_r2_merge.sv
// Final radix-2 merge of two N/2-point spectra: X[k] = E[k] + W^k O[k], X[k+N/2] = E[k] - W^k O[k].
// One butterfly per cycle through a read / multiply / round-add-write pipeline.
module fft_r2_merge
    import fft_pkg::*;
#(
    parameter int DW    = 18,
    parameter int LOG2N = 4,
    parameter int SCALE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_we,
    input  logic                   in_sel,
    input  logic [LOG2N-2:0]       in_addr,
    input  logic signed [DW-1:0]   in_r,
    input  logic signed [DW-1:0]   in_i,
    input  logic [LOG2N-1:0]       out_addr,
    output logic signed [DW:0]     out_r,
    output logic signed [DW:0]     out_i,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf
);

    localparam int HALF = 1 << (LOG2N - 1);
    localparam int AW   = LOG2N - 1;
    localparam int OW   = DW + 1;
    localparam int PW   = DW + TW_W;
    localparam int SW   = PW + 1;
    localparam int RW   = SW - TW_FRAC;
    localparam int XW   = RW + 1;

    function automatic logic signed [RW-1:0] round_tw(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] t;
        t = v + SW'(RND_CONST);
        return RW'(t >>> TW_FRAC);
    endfunction

    function automatic logic signed [XW-1:0] scale_sum(input logic signed [XW-1:0] v);
        if (SCALE != 0)
            return (v + XW'(1)) >>> 1;
        else
            return v;
    endfunction

    // A value fits the output width when all bits from the output sign bit upward agree.
    function automatic logic sat_hit(input logic signed [XW-1:0] v);
        return !((&v[XW-1:OW-1]) || !(|v[XW-1:OW-1]));
    endfunction

    function automatic logic signed [OW-1:0] sat_ow(input logic signed [XW-1:0] v);
        if (!sat_hit(v))
            return v[OW-1:0];
        else if (v[XW-1])
            return {1'b1, {(OW-1){1'b0}}};
        else
            return {1'b0, {(OW-1){1'b1}}};
    endfunction

    state_t            r_state;
    logic [AW-1:0]     r_k;
    logic              r_busy;
    logic              r_done;
    logic              r_ovf;

    logic signed [DW-1:0] r_e_r [HALF];
    logic signed [DW-1:0] r_e_i [HALF];
    logic signed [DW-1:0] r_o_r [HALF];
    logic signed [DW-1:0] r_o_i [HALF];

    logic signed [OW-1:0] r_xlo_r [HALF];
    logic signed [OW-1:0] r_xlo_i [HALF];
    logic signed [OW-1:0] r_xhi_r [HALF];
    logic signed [OW-1:0] r_xhi_i [HALF];
    logic signed [OW-1:0] r_out_r;
    logic signed [OW-1:0] r_out_i;

    logic                 r_vld_p1, r_vld_p2, r_vld_p3;
    logic [AW-1:0]        r_k_p1, r_k_p2, r_k_p3;
    logic signed [DW-1:0] r_er_p1, r_ei_p1, r_or_p1, r_oi_p1;
    logic signed [DW-1:0] r_er_p2, r_ei_p2;
    logic signed [PW-1:0] r_m_rr_p2, r_m_ii_p2, r_m_ri_p2, r_m_ir_p2;
    logic signed [OW-1:0] r_xa_r_p3, r_xa_i_p3, r_xb_r_p3, r_xb_i_p3;

    logic signed [TW_W-1:0] w_tw_r, w_tw_i;
    logic signed [RW-1:0]   w_pr, w_pi;
    logic signed [XW-1:0]   w_a_r, w_a_i, w_b_r, w_b_i;
    logic                   w_sat_hit;
    logic                   w_in_wr;

    assign w_in_wr = in_we && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_ovf   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_k <= r_k + 1'b1;
                    if (r_k == AW'(HALF - 1))
                        r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Only the final write stage may still be in flight; it completes this edge.
                    if (!r_vld_p1 && !r_vld_p2) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            if (w_sat_hit)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_wr) begin
            if (!in_sel) begin
                r_e_r[in_addr] <= in_r;
                r_e_i[in_addr] <= in_i;
            end else begin
                r_o_r[in_addr] <= in_r;
                r_o_i[in_addr] <= in_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
        end else begin
            r_vld_p1 <= (r_state == ST_RUN);
            r_vld_p2 <= r_vld_p1;
            r_vld_p3 <= r_vld_p2;
        end
    end

    fft_twiddle_rom #(
        .LOG2N (LOG2N)
    ) u_tw (
        .i_clk  (clk),
        .i_addr (r_k),
        .o_tw_r (w_tw_r),
        .o_tw_i (w_tw_i)
    );

    // Stage p1: input buffer read (twiddle arrives from the ROM in the same cycle).
    always_ff @(posedge clk) begin
        r_k_p1  <= r_k;
        r_er_p1 <= r_e_r[r_k];
        r_ei_p1 <= r_e_i[r_k];
        r_or_p1 <= r_o_r[r_k];
        r_oi_p1 <= r_o_i[r_k];
    end

    // Stage p2: full-precision partial products of O[k] * W^k.
    always_ff @(posedge clk) begin
        r_k_p2    <= r_k_p1;
        r_er_p2   <= r_er_p1;
        r_ei_p2   <= r_ei_p1;
        r_m_rr_p2 <= r_or_p1 * w_tw_r;
        r_m_ii_p2 <= r_oi_p1 * w_tw_i;
        r_m_ri_p2 <= r_or_p1 * w_tw_i;
        r_m_ir_p2 <= r_oi_p1 * w_tw_r;
    end

    // Stage p3: round product, add/subtract, optional halving, saturate; write next edge.
    assign w_pr  = round_tw(SW'(r_m_rr_p2) - SW'(r_m_ii_p2));
    assign w_pi  = round_tw(SW'(r_m_ri_p2) + SW'(r_m_ir_p2));
    assign w_a_r = scale_sum(XW'(r_er_p2) + XW'(w_pr));
    assign w_a_i = scale_sum(XW'(r_ei_p2) + XW'(w_pi));
    assign w_b_r = scale_sum(XW'(r_er_p2) - XW'(w_pr));
    assign w_b_i = scale_sum(XW'(r_ei_p2) - XW'(w_pi));
    assign w_sat_hit = r_vld_p2 &&
        (sat_hit(w_a_r) || sat_hit(w_a_i) || sat_hit(w_b_r) || sat_hit(w_b_i));

    always_ff @(posedge clk) begin
        r_k_p3    <= r_k_p2;
        r_xa_r_p3 <= sat_ow(w_a_r);
        r_xa_i_p3 <= sat_ow(w_a_i);
        r_xb_r_p3 <= sat_ow(w_b_r);
        r_xb_i_p3 <= sat_ow(w_b_i);
    end

    // Output buffer: N entries split by address MSB so both butterfly legs write in one cycle.
    always_ff @(posedge clk) begin
        if (r_vld_p3) begin
            r_xlo_r[r_k_p3] <= r_xa_r_p3;
            r_xlo_i[r_k_p3] <= r_xa_i_p3;
            r_xhi_r[r_k_p3] <= r_xb_r_p3;
            r_xhi_i[r_k_p3] <= r_xb_i_p3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_r <= '0;
            r_out_i <= '0;
        end else if (out_addr[AW]) begin
            r_out_r <= r_xhi_r[out_addr[AW-1:0]];
            r_out_i <= r_xhi_i[out_addr[AW-1:0]];
        end else begin
            r_out_r <= r_xlo_r[out_addr[AW-1:0]];
            r_out_i <= r_xlo_i[out_addr[AW-1:0]];
        end
    end

    assign out_r = r_out_r;
    assign out_i = r_out_i;
    assign busy  = r_busy;
    assign done  = r_done;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_fft_r2_merge.sv
// Directed bench for fft_r2_merge (N=16, DW=18) with SCALE=0 and SCALE=1 instances
// driven in parallel; read-back expectations flow through a scoreboard queue.
module tb_fft_r2_merge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_we = 1'b0;
    logic              in_sel = 1'b0;
    logic [2:0]        in_addr = '0;
    logic signed [17:0] in_r = '0;
    logic signed [17:0] in_i = '0;
    logic [3:0]        out_addr = '0;
    logic signed [18:0] out_r0, out_i0, out_r1, out_i1;
    logic              busy0, done0, ovf0, busy1, done1, ovf1;

    fft_r2_merge #(.DW(18), .LOG2N(4), .SCALE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .in_we(in_we), .in_sel(in_sel),
        .in_addr(in_addr), .in_r(in_r), .in_i(in_i), .out_addr(out_addr),
        .out_r(out_r0), .out_i(out_i0), .busy(busy0), .done(done0), .ovf(ovf0));

    fft_r2_merge #(.DW(18), .LOG2N(4), .SCALE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .in_we(in_we), .in_sel(in_sel),
        .in_addr(in_addr), .in_r(in_r), .in_i(in_i), .out_addr(out_addr),
        .out_r(out_r1), .out_i(out_i1), .busy(busy1), .done(done1), .ovf(ovf1));

    typedef struct {
        int a;
        int r0;
        int i0;
        int r1;
        int i1;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    int me_r[8], me_i[8], mo_r[8], mo_i[8];
    int x0_r[16], x0_i[16], x1_r[16], x1_i[16];
    int xo0, xo1;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd(input real x);
        return int'($floor(x + 0.5));
    endfunction

    function automatic int bsat(input longint v);
        if (v > 262143) return 262143;
        if (v < -262144) return -262144;
        return int'(v);
    endfunction

    task automatic model();
        xo0 = 0;
        xo1 = 0;
        for (int k = 0; k < 8; k++) begin
            real    ang;
            int     tr, ti;
            longint pr, pi, p_r, p_i;
            longint s[4];
            ang = 2.0 * 3.14159265358979 * real'(k) / 16.0;
            tr  = rnd(16384.0 * $cos(ang));
            ti  = rnd(-16384.0 * $sin(ang));
            pr  = longint'(mo_r[k]) * tr - longint'(mo_i[k]) * ti;
            pi  = longint'(mo_r[k]) * ti + longint'(mo_i[k]) * tr;
            p_r = (pr + 8192) >>> 14;
            p_i = (pi + 8192) >>> 14;
            s[0] = me_r[k] + p_r;
            s[1] = me_i[k] + p_i;
            s[2] = me_r[k] - p_r;
            s[3] = me_i[k] - p_i;
            x0_r[k] = bsat(s[0]); x0_i[k] = bsat(s[1]);
            x0_r[k+8] = bsat(s[2]); x0_i[k+8] = bsat(s[3]);
            x1_r[k] = bsat((s[0] + 1) >>> 1); x1_i[k] = bsat((s[1] + 1) >>> 1);
            x1_r[k+8] = bsat((s[2] + 1) >>> 1); x1_i[k+8] = bsat((s[3] + 1) >>> 1);
            for (int j = 0; j < 4; j++) begin
                if (longint'(bsat(s[j])) != s[j]) xo0 = 1;
                if (longint'(bsat((s[j] + 1) >>> 1)) != ((s[j] + 1) >>> 1)) xo1 = 1;
            end
        end
    endtask

    task automatic wr(input bit sel, input int a, input int r, input int i);
        @(negedge clk);
        in_we = 1'b1; in_sel = sel; in_addr = 3'(a); in_r = 18'(r); in_i = 18'(i);
        @(posedge clk); #1;
        in_we = 1'b0;
        if (sel) begin mo_r[a] = r; mo_i[a] = i; end
        else     begin me_r[a] = r; me_i[a] = i; end
    endtask

    task automatic do_pass(input string tag, input bit disturb, input int rst_at,
                           input bit wr0, input int wr0_val);
        int nd0 = 0, nd1 = 0, first = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            start   = (cyc == 0) || (disturb && (cyc == 3 || cyc == 7));
            in_we   = (wr0 && cyc == 0) || (disturb && cyc == 5);
            in_sel  = 1'b0;
            in_addr = wr0 ? 3'd0 : 3'd3;
            in_r    = wr0 ? 18'(wr0_val) : 18'sd12345;
            in_i    = '0;
            rst     = (rst_at > 0) && (cyc == rst_at);
            @(posedge clk); #1;
            if (done0) begin nd0++; if (first < 0) first = cyc + 1; end
            if (done1) nd1++;
            if (cyc == 0) begin
                check({tag, "_busy_c1"}, busy0, 1);
                check({tag, "_ovf_clr"}, ovf0, 0);
            end
            if (rst_at > 0 && cyc == rst_at) check({tag, "_busy_after_rst"}, busy0, 0);
            if (rst_at == 0 && cyc == 11) check({tag, "_busy_on_done"}, busy0, 0);
        end
        start = 1'b0; in_we = 1'b0; rst = 1'b0;
        if (wr0) begin me_r[0] = wr0_val; me_i[0] = 0; end
        if (rst_at > 0) begin
            check({tag, "_ndone0"}, nd0, 0);
            check({tag, "_ndone1"}, nd1, 0);
        end else begin
            check({tag, "_done_cycle"}, first, 12);
            check({tag, "_ndone0"}, nd0, 1);
            check({tag, "_ndone1"}, nd1, 1);
        end
    endtask

    task automatic chk_all(input string tag);
        exp_t e;
        model();
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            out_addr = 4'(a);
            q.push_back('{a, x0_r[a], x0_i[a], x1_r[a], x1_i[a]});
            @(posedge clk); #1;
            e = q.pop_front();
            check($sformatf("%s_X%0d_r_s0", tag, e.a), out_r0, e.r0);
            check($sformatf("%s_X%0d_i_s0", tag, e.a), out_i0, e.i0);
            check($sformatf("%s_X%0d_r_s1", tag, e.a), out_r1, e.r1);
            check($sformatf("%s_X%0d_i_s1", tag, e.a), out_i1, e.i1);
        end
        check({tag, "_ovf0"}, ovf0, xo0);
        check({tag, "_ovf1"}, ovf1, xo1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_out_r", out_r0, 0);
        check("rst_out_i", out_i0, 0);
        check("rst_busy1", busy1, 0);
        check("rst_out_r1", out_r1, 0);
        @(negedge clk);
        rst = 1'b0;

        // Constant E, zero O: every bin equals E
        for (int k = 0; k < 8; k++) begin
            wr(1'b0, k, 1000, 0);
            wr(1'b1, k, 0, 0);
        end
        do_pass("A", 1'b0, 0, 1'b0, 0);
        chk_all("A");

        // Single odd tone at k=4 rotates by -j
        for (int k = 0; k < 8; k++) wr(1'b0, k, 0, 0);
        wr(1'b1, 4, 1000, 0);
        do_pass("B", 1'b0, 0, 1'b0, 0);
        chk_all("B");

        // Full-scale inputs at k=2 force saturation
        wr(1'b0, 2, 131071, 0);
        wr(1'b1, 2, 131071, 131071);
        do_pass("C", 1'b0, 0, 1'b0, 0);
        chk_all("C");
        check("C_ovf_set", ovf0, 1);

        // Write coinciding with start lands first; start clears ovf
        for (int k = 0; k < 8; k++) wr(1'b0, k, 1000, 0);
        wr(1'b1, 2, 0, 0);
        wr(1'b1, 4, 0, 0);
        do_pass("D", 1'b0, 0, 1'b1, 2000);
        chk_all("D");

        // Repeated start and a write while busy are ignored
        do_pass("E", 1'b1, 0, 1'b0, 0);
        chk_all("E");

        // Reset mid-pass aborts; a fresh pass reproduces the constant-E result
        wr(1'b0, 0, 1000, 0);
        do_pass("F_abort", 1'b0, 6, 1'b0, 0);
        do_pass("F", 1'b0, 0, 1'b0, 0);
        chk_all("F");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
